// File: rtl/serializer_pkg.sv
// Shared definitions for the word-to-beat serializer: FSM state encoding and
// beat-counter sizing.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Beat counter needs at least one bit even when a word is a single beat.
    function automatic int unsigned beat_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_control_shifter.sv
// Parallel-load shift register of `count` slices of `width` bits; shifts
// toward slice 0, which is presented on serial_out. Contents are not reset.
module shifter #(
    parameter int unsigned count = 4,
    parameter int unsigned width = 8
) (
    input  logic                     clock,
    input  logic                     enable,
    input  logic                     load,
    input  logic [count*width-1:0]   parallel_in,
    input  logic [width-1:0]         serial_in,
    output logic [width-1:0]         serial_out
);

    logic [count*width-1:0] data_q;
    logic [count*width-1:0] data_d;
    logic [count*width-1:0] shifted;

    generate
        if (count == 1) begin : g_single
            assign shifted = serial_in;
        end else begin : g_multi
            assign shifted = {serial_in, data_q[count*width-1:width]};
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (enable) begin
            data_d = load ? parallel_in : shifted;
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign serial_out = data_q[width-1:0];

endmodule

// File: rtl/serializer_control.sv
// Sequences a shifter as a word-to-beat serializer: one count*width word in,
// count beats of width bits out, LSB slice first, with zero-bubble reload.
module serializer_control
    import serializer_pkg::*;
#(
    parameter int unsigned count = 4,
    parameter int unsigned width = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [count*width-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [width-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    input  logic                     flush,
    output logic                     busy
);

    localparam int unsigned BW = beat_width(count);
    localparam logic [BW-1:0] LAST_BEAT = BW'(count - 1);

    state_t          state_q;
    state_t          state_d;
    logic [BW-1:0]   beat_q;
    logic [BW-1:0]   beat_d;
    logic            sh_enable;
    logic            sh_load;
    logic [width-1:0] sh_out;

    shifter #(
        .count (count),
        .width (width)
    ) u_shifter (
        .clock       (clock),
        .enable      (sh_enable),
        .load        (sh_load),
        .parallel_in (in_data),
        .serial_in   ('0),
        .serial_out  (sh_out)
    );

    assign out_valid = (state_q == SHIFT);
    assign busy      = out_valid;
    assign out_last  = out_valid && (beat_q == LAST_BEAT);
    // Combinational from out_ready so a new word can load on the last beat.
    assign in_ready  = !flush && ((state_q == IDLE) || (out_last && out_ready));
    assign out_data  = out_valid ? sh_out : '0;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        sh_enable = 1'b0;
        sh_load   = 1'b0;
        if (flush) begin
            // The beat shown during a flush is discarded, not transferred.
            if (state_q == SHIFT) begin
                state_d = IDLE;
                beat_d  = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh_enable = 1'b1;
                        sh_load   = 1'b1;
                        beat_d    = '0;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (!out_last) begin
                            sh_enable = 1'b1;
                            beat_d    = beat_q + BW'(1);
                        end else if (in_valid) begin
                            sh_enable = 1'b1;
                            sh_load   = 1'b1;
                            beat_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_serializer_control.sv
// Directed bench for serializer_control: a count=4 instance for word/beat
// sequencing, backpressure, flush and reset, plus a count=1 instance.
module tb_serializer_control;

    logic        clock;
    logic        reset;

    logic [31:0] a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic        a_out_last;
    logic        a_flush;
    logic        a_busy;

    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_out_last;
    logic        b_flush;
    logic        b_busy;

    int unsigned n_checks;
    int unsigned n_pass;

    serializer_control #(
        .count (4),
        .width (8)
    ) u_dut4 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_last  (a_out_last),
        .flush     (a_flush),
        .busy      (a_busy)
    );

    serializer_control #(
        .count (1),
        .width (8)
    ) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_last  (b_out_last),
        .flush     (b_flush),
        .busy      (b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the count=4 instance is presenting a given beat.
    task automatic beat4(input string tag, input logic [7:0] data, input logic last,
                         input logic rdy);
        check({tag, ".valid"}, {31'd0, a_out_valid}, 32'd1);
        check({tag, ".data"}, {24'd0, a_out_data}, {24'd0, data});
        check({tag, ".last"}, {31'd0, a_out_last}, {31'd0, last});
        check({tag, ".in_ready"}, {31'd0, a_in_ready}, {31'd0, rdy});
    endtask

    task automatic idle4(input string tag);
        check({tag, ".valid"}, {31'd0, a_out_valid}, 32'd0);
        check({tag, ".busy"}, {31'd0, a_busy}, 32'd0);
        check({tag, ".last"}, {31'd0, a_out_last}, 32'd0);
        check({tag, ".data"}, {24'd0, a_out_data}, 32'd0);
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic half;
        @(negedge clock);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        a_in_data   = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        a_flush     = 1'b0;
        b_in_data   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        b_flush     = 1'b0;

        #12;
        idle4("rst");
        check("rst.in_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst1.valid", {31'd0, b_out_valid}, 32'd0);
        check("rst1.in_ready", {31'd0, b_in_ready}, 32'd1);
        half;
        reset = 1'b0;

        // Basic word
        half; a_in_data = 32'h44332211; a_in_valid = 1'b1; #1;
        check("basic.accept", {31'd0, a_in_ready}, 32'd1);
        half; a_in_valid = 1'b0; #1; beat4("basic.b0", 8'h11, 1'b0, 1'b0);
        half; #1; beat4("basic.b1", 8'h22, 1'b0, 1'b0);
        half; #1; beat4("basic.b2", 8'h33, 1'b0, 1'b0);
        half; #1; beat4("basic.b3", 8'h44, 1'b1, 1'b1);
        half; #1; idle4("basic.idle");

        // Back-to-back words with in_valid held
        half; a_in_data = 32'h44332211; a_in_valid = 1'b1; #1;
        half; a_in_data = 32'h88776655; #1; beat4("b2b.b0", 8'h11, 1'b0, 1'b0);
        half; #1; beat4("b2b.b1", 8'h22, 1'b0, 1'b0);
        half; #1; beat4("b2b.b2", 8'h33, 1'b0, 1'b0);
        half; #1; beat4("b2b.b3", 8'h44, 1'b1, 1'b1);
        half; a_in_valid = 1'b0; #1; beat4("b2b.b4", 8'h55, 1'b0, 1'b0);
        half; #1; beat4("b2b.b5", 8'h66, 1'b0, 1'b0);
        half; #1; beat4("b2b.b6", 8'h77, 1'b0, 1'b0);
        half; #1; beat4("b2b.b7", 8'h88, 1'b1, 1'b1);
        half; #1; idle4("b2b.idle");

        // Backpressure on beat 22
        half; a_in_data = 32'h44332211; a_in_valid = 1'b1; #1;
        half; a_in_valid = 1'b0; #1; beat4("bp.b0", 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            half; a_out_ready = 1'b0; #1; beat4("bp.hold", 8'h22, 1'b0, 1'b0);
        end
        half; a_out_ready = 1'b1; #1; beat4("bp.b1", 8'h22, 1'b0, 1'b0);
        half; #1; beat4("bp.b2", 8'h33, 1'b0, 1'b0);
        half; a_out_ready = 1'b0; #1; beat4("bp.b3_held", 8'h44, 1'b1, 1'b0);
        half; a_out_ready = 1'b1; #1; beat4("bp.b3", 8'h44, 1'b1, 1'b1);
        half; #1; idle4("bp.idle");

        // Flush on beat 33, then a fresh word
        half; a_in_data = 32'h44332211; a_in_valid = 1'b1; #1;
        half; a_in_valid = 1'b0; #1; beat4("fl.b0", 8'h11, 1'b0, 1'b0);
        half; #1; beat4("fl.b1", 8'h22, 1'b0, 1'b0);
        half; a_flush = 1'b1; #1; beat4("fl.b2", 8'h33, 1'b0, 1'b0);
        half; a_flush = 1'b0; #1; idle4("fl.after");
        half; a_flush = 1'b1; a_in_data = 32'hDDCCBBAA; a_in_valid = 1'b1; #1;
        check("fl.idle_block", {31'd0, a_in_ready}, 32'd0);
        half; #1; idle4("fl.idle_hold");
        a_flush = 1'b0; #1;
        check("fl.accept", {31'd0, a_in_ready}, 32'd1);
        half; a_in_valid = 1'b0; #1; beat4("fl.n0", 8'hAA, 1'b0, 1'b0);
        half; #1; beat4("fl.n1", 8'hBB, 1'b0, 1'b0);
        half; #1; beat4("fl.n2", 8'hCC, 1'b0, 1'b0);
        half; #1; beat4("fl.n3", 8'hDD, 1'b1, 1'b1);
        half; #1; idle4("fl.idle");

        // Asynchronous reset while beat 22 is shown
        half; a_in_data = 32'h44332211; a_in_valid = 1'b1; #1;
        half; a_in_valid = 1'b0; #1; beat4("rs.b0", 8'h11, 1'b0, 1'b0);
        half; #1; beat4("rs.b1", 8'h22, 1'b0, 1'b0);
        #1; reset = 1'b1; #1;
        idle4("rs.async");
        check("rs.in_ready", {31'd0, a_in_ready}, 32'd1);
        #1; reset = 1'b0;
        half; a_in_data = 32'h0D0C0B0A; a_in_valid = 1'b1; #1;
        half; a_in_valid = 1'b0; #1; beat4("rs.n0", 8'h0A, 1'b0, 1'b0);
        half; #1; beat4("rs.n1", 8'h0B, 1'b0, 1'b0);
        half; #1; beat4("rs.n2", 8'h0C, 1'b0, 1'b0);
        half; #1; beat4("rs.n3", 8'h0D, 1'b1, 1'b1);
        half; #1; idle4("rs.idle");

        // count = 1: one beat per word, every beat last
        half; b_in_data = 8'h5A; b_in_valid = 1'b1; #1;
        check("c1.accept", {31'd0, b_in_ready}, 32'd1);
        half; b_in_data = 8'hA5; #1;
        check("c1.b0.data", {24'd0, b_out_data}, 32'h5A);
        check("c1.b0.last", {31'd0, b_out_last}, 32'd1);
        check("c1.b0.valid", {31'd0, b_out_valid}, 32'd1);
        check("c1.b0.in_ready", {31'd0, b_in_ready}, 32'd1);
        half; b_in_valid = 1'b0; #1;
        check("c1.b1.data", {24'd0, b_out_data}, 32'hA5);
        check("c1.b1.last", {31'd0, b_out_last}, 32'd1);
        check("c1.b1.valid", {31'd0, b_out_valid}, 32'd1);
        half; #1;
        check("c1.idle.valid", {31'd0, b_out_valid}, 32'd0);
        check("c1.idle.data", {24'd0, b_out_data}, 32'd0);
        check("c1.idle.busy", {31'd0, b_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
